// File: rtl/byte_data_memory.sv
// rtl/byte_data_memory.sv - word-organised data memory with byte/halfword/word loads and stores
module byte_data_memory #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        err
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic           we_q;
  logic [2:0]     size_q;
  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic           resp_valid_q;
  logic           err_q;
  logic [31:0]    read_data_q;

  // Contents start at zero and are deliberately untouched by reset
  logic [31:0]    mem_q [DEPTH] = '{default: '0};

  logic [AW-1:0]  idx;
  logic [31:0]    word;
  logic           access;
  logic           req_err;
  logic [7:0]     lane_byte;
  logic [15:0]    lane_half;
  logic [31:0]    load_d;
  logic [3:0]     wmask_d;
  logic [31:0]    wlanes_d;
  logic           unused_addr_hi;

  // Address bits above the array simply wrap around
  assign unused_addr_hi = ^address[31:AW+2];

  assign idx        = addr_q[AW+1:2];
  assign word       = mem_q[idx];
  assign access     = (state_q == S_WAIT) && (cnt_q == LAST_CNT);
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign read_data  = read_data_q;
  assign err        = err_q;

  // Reserved encodings and misaligned halfword/word requests are rejected at acceptance
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = address[0];
      3'b010:         req_err = |address[1:0];
      default:        req_err = 1'b1;
    endcase
  end

  // Lane selection and sign/zero extension of the addressed word for loads
  always_comb begin
    load_d    = '0;
    lane_byte = word[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? word[31:16] : word[15:0];
    case (size_q)
      3'b000:  load_d = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_d = {24'h0, lane_byte};
      3'b001:  load_d = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_d = {16'h0, lane_half};
      3'b010:  load_d = word;
      default: load_d = '0;
    endcase
  end

  // Byte-enable mask and lane-replicated store data
  always_comb begin
    wmask_d  = 4'b0000;
    wlanes_d = wdata_q;
    case (size_q[1:0])
      2'b00: begin
        wmask_d  = 4'b0001 << addr_q[1:0];
        wlanes_d = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask_d  = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes_d = {2{wdata_q[15:0]}};
      end
      2'b10:   wmask_d = 4'b1111;
      default: wmask_d = 4'b0000;
    endcase
  end

  // Array write only on the WAIT->RESP edge; a reset held across that edge aborts it
  always_ff @(posedge clk) begin
    if (access && we_q && rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_d[i]) mem_q[idx][8*i +: 8] <= wlanes_d[8*i +: 8];
      end
    end
  end

  // Request/response sequencer with registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      size_q       <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      read_data_q  <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            addr_q  <= address[AW+1:0];
            wdata_q <= write_data;
            cnt_q   <= 4'd0;
            if (req_err) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              err_q        <= 1'b1;
              read_data_q  <= 32'h0;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == LAST_CNT) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b0;
            read_data_q  <= we_q ? 32'h0 : load_d;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_byte_data_memory.sv
// tb/tb_byte_data_memory.sv - randomized and directed bench for byte_data_memory
module tb_byte_data_memory;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } dir_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [3:0]  req_valid = 4'b0000;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [3:0]  err;
  logic [31:0] read_data [4];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mdl [4][DEPTH*4];

  always #5 clk = ~clk;

  byte_data_memory #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_size(req_size), .address(address), .write_data(write_data),
    .resp_valid(resp_valid[0]), .read_data(read_data[0]), .err(err[0]));
  byte_data_memory #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_size(req_size), .address(address), .write_data(write_data),
    .resp_valid(resp_valid[1]), .read_data(read_data[1]), .err(err[1]));
  byte_data_memory #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_size(req_size), .address(address), .write_data(write_data),
    .resp_valid(resp_valid[2]), .read_data(read_data[2]), .err(err[2]));
  byte_data_memory #(.DEPTH(DEPTH), .WAIT_STATES(15)) u_ws15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
    .req_we(req_we), .req_size(req_size), .address(address), .write_data(write_data),
    .resp_valid(resp_valid[3]), .read_data(read_data[3]), .err(err[3]));

  function automatic int ws_of(input int k);
    case (k)
      0: return 1;
      1: return 3;
      2: return 0;
      default: return 15;
    endcase
  endfunction

  // Reference model: byte-addressed array, accesses of 1/2/4 bytes, little-endian
  function automatic bit mdl_err(input logic [2:0] size, input logic [31:0] addr);
    case (size)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return (addr % 2) != 0;
      3'b010:         return (addr % 4) != 0;
      default:        return 1'b1;
    endcase
  endfunction

  task automatic model_access(input int k, input bit we, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output bit e, output int lat);
    int n;
    int base;
    logic [31:0] v;
    e  = mdl_err(size, addr);
    rd = 32'h0;
    lat = 0;
    if (e) return;
    lat  = ws_of(k) + 1;
    n    = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
    base = int'(addr % (DEPTH*4));
    if (we) begin
      for (int i = 0; i < n; i++) mdl[k][base+i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[k][base+i];
      if (!size[2] && n < 4 && v[8*n-1]) begin
        for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      end
      rd = v;
    end
  endtask

  task automatic do_access(input int k, input bit we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output bit e, output int lat,
                           output bit one_cycle);
    int guard;
    @(negedge clk);
    req_we = we; req_size = size; address = addr; write_data = wd;
    req_valid[k] = 1'b1;
    guard = 0;
    while (!req_ready[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_we = 1'($urandom); req_size = 3'($urandom);
    address = $urandom; write_data = $urandom;
    lat = 0;
    while (!resp_valid[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = read_data[k];
    e  = err[k];
    @(posedge clk);
    #1;
    one_cycle = !resp_valid[k] && (lat < 40);
  endtask

  function automatic dir_t dir_op(input int t, input int i);
    case ({t[3:0], i[3:0]})
      8'h00: return '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
      8'h01: return '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
      8'h10: return '{1'b1, 3'b000, 32'h13,   32'h7F,       32'h0,        1'b0};
      8'h11: return '{1'b0, 3'b000, 32'h13,   32'h0,        32'h0000007F, 1'b0};
      8'h12: return '{1'b0, 3'b100, 32'h12,   32'h0,        32'h000000AD, 1'b0};
      8'h13: return '{1'b0, 3'b000, 32'h12,   32'h0,        32'hFFFFFFAD, 1'b0};
      8'h14: return '{1'b0, 3'b001, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b0};
      8'h15: return '{1'b0, 3'b101, 32'h12,   32'h0,        32'h00007FAD, 1'b0};
      8'h20: return '{1'b0, 3'b010, 32'h11,   32'h0,        32'h0,        1'b1};
      8'h21: return '{1'b1, 3'b001, 32'h13,   32'hFFFF,     32'h0,        1'b1};
      8'h22: return '{1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1};
      8'h23: return '{1'b1, 3'b110, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1};
      8'h24: return '{1'b0, 3'b111, 32'h10,   32'h0,        32'h0,        1'b1};
      8'h25: return '{1'b0, 3'b010, 32'h10,   32'h0,        32'h7FADBEEF, 1'b0};
      8'h30: return '{1'b1, 3'b010, 32'h1004, 32'h12345678, 32'h0,        1'b0};
      8'h31: return '{1'b0, 3'b010, 32'h4,    32'h0,        32'h12345678, 1'b0};
      default: return '0;
    endcase
  endfunction

  task automatic test_reset;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0 || err[k] !== 1'b0 || read_data[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: got ready=%b resp=%b err=%b rd=%h expected 1 0 0 00000000",
                 k, req_ready[k], resp_valid[k], err[k], read_data[k]);
      end
    end
    // Request present on the very first edge after release, reading never-written memory
    rst_n = 1'b1;
    req_we = 1'b0; req_size = 3'b010; address = 32'h8; req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    vectors++;
    if (req_ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL first_edge_accept: got ready=%b expected 0", req_ready[0]);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (resp_valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL first_accept_early_resp: got %b expected 0", resp_valid[0]);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (resp_valid[0] !== 1'b1 || read_data[0] !== 32'h0 || err[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL first_accept_resp: got resp=%b rd=%h err=%b expected 1 00000000 0",
               resp_valid[0], read_data[0], err[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_word_rw;
    dir_t op; logic [31:0] rd, mrd; bit e, me, oc; int lat, mlat;
    for (int i = 0; i < 2; i++) begin
      op = dir_op(0, i);
      model_access(0, op.we, op.size, op.addr, op.wd, mrd, me, mlat);
      do_access(0, op.we, op.size, op.addr, op.wd, rd, e, lat, oc);
      vectors++;
      if (rd !== op.exp_rd || e !== op.exp_err || lat !== mlat || !oc) begin
        miscompares++;
        $display("FAIL word_rw[%0d]: got rd=%h err=%b lat=%0d pulse1=%b expected rd=%h err=%b lat=%0d pulse1=1",
                 i, rd, e, lat, oc, op.exp_rd, op.exp_err, mlat);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (read_data[0] !== 32'hDEADBEEF || err[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL read_data_hold: got rd=%h err=%b expected deadbeef 0", read_data[0], err[0]);
    end
  endtask

  task automatic test_subword;
    dir_t op; logic [31:0] rd, mrd; bit e, me, oc; int lat, mlat;
    for (int i = 0; i < 6; i++) begin
      op = dir_op(1, i);
      model_access(0, op.we, op.size, op.addr, op.wd, mrd, me, mlat);
      do_access(0, op.we, op.size, op.addr, op.wd, rd, e, lat, oc);
      vectors++;
      if (rd !== op.exp_rd || e !== op.exp_err || lat !== mlat || !oc) begin
        miscompares++;
        $display("FAIL subword[%0d]: got rd=%h err=%b lat=%0d pulse1=%b expected rd=%h err=%b lat=%0d pulse1=1",
                 i, rd, e, lat, oc, op.exp_rd, op.exp_err, mlat);
      end
    end
  endtask

  task automatic test_errors;
    dir_t op; logic [31:0] rd, mrd; bit e, me, oc; int lat, mlat;
    for (int i = 0; i < 6; i++) begin
      op = dir_op(2, i);
      model_access(0, op.we, op.size, op.addr, op.wd, mrd, me, mlat);
      do_access(0, op.we, op.size, op.addr, op.wd, rd, e, lat, oc);
      vectors++;
      if (rd !== op.exp_rd || e !== op.exp_err || lat !== mlat || !oc) begin
        miscompares++;
        $display("FAIL errors[%0d]: got rd=%h err=%b lat=%0d pulse1=%b expected rd=%h err=%b lat=%0d pulse1=1",
                 i, rd, e, lat, oc, op.exp_rd, op.exp_err, mlat);
      end
    end
  endtask

  task automatic test_wrap;
    dir_t op; logic [31:0] rd, mrd; bit e, me, oc; int lat, mlat;
    for (int i = 0; i < 2; i++) begin
      op = dir_op(3, i);
      model_access(0, op.we, op.size, op.addr, op.wd, mrd, me, mlat);
      do_access(0, op.we, op.size, op.addr, op.wd, rd, e, lat, oc);
      vectors++;
      if (rd !== op.exp_rd || e !== op.exp_err || lat !== mlat || !oc) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got rd=%h err=%b lat=%0d expected rd=%h err=%b lat=%0d",
                 i, rd, e, lat, op.exp_rd, op.exp_err, mlat);
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, mrd; bit e, me, oc, seen; int lat, mlat;
    model_access(1, 1'b1, 3'b010, 32'h20, 32'hA5A55A5A, mrd, me, mlat);
    do_access(1, 1'b1, 3'b010, 32'h20, 32'hA5A55A5A, rd, e, lat, oc);
    vectors++;
    if (lat !== 4 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL ws3_latency: got lat=%0d err=%b expected 4 0", lat, e);
    end
    @(negedge clk);
    req_we = 1'b1; req_size = 3'b010; address = 32'h20; write_data = 32'hFFFFFFFF;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    seen = resp_valid[1];
    @(posedge clk);
    #1;
    seen |= resp_valid[1];
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen |= resp_valid[1];
    end
    rst_n = 1'b1;
    vectors++;
    if (req_ready[1] !== 1'b1 || read_data[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_ready: got ready=%b rd=%h expected 1 00000000", req_ready[1], read_data[1]);
    end
    repeat (8) begin
      @(posedge clk);
      #1;
      seen |= resp_valid[1];
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_resp: got resp seen=%b expected 0", seen);
    end
    model_access(1, 1'b0, 3'b010, 32'h20, 32'h0, mrd, me, mlat);
    do_access(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat, oc);
    vectors++;
    if (rd !== 32'hA5A55A5A || rd !== mrd || e !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_prior_value: got rd=%h err=%b expected a5a55a5a 0", rd, e);
    end
  endtask

  task automatic test_latency;
    logic [31:0] rd, mrd, wd; logic [31:0] addr; bit e, me, oc; int lat, mlat, guard;
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      addr = $urandom & 32'h0000_0FFC;
      for (int j = 0; j < 2; j++) begin
        model_access(2, (j == 0), 3'b010, addr, wd, mrd, me, mlat);
        do_access(2, (j == 0), 3'b010, addr, wd, rd, e, lat, oc);
        vectors++;
        if (lat !== 1 || rd !== mrd || e !== 1'b0 || !oc) begin
          miscompares++;
          $display("FAIL ws0[%0d.%0d]: got lat=%0d rd=%h err=%b expected lat=1 rd=%h err=0", i, j, lat, rd, e, mrd);
        end
      end
    end
    wd = $urandom;
    for (int j = 0; j < 2; j++) begin
      model_access(3, (j == 0), 3'b010, 32'h40, wd, mrd, me, mlat);
      do_access(3, (j == 0), 3'b010, 32'h40, wd, rd, e, lat, oc);
      vectors++;
      if (lat !== 16 || rd !== mrd || e !== 1'b0 || !oc) begin
        miscompares++;
        $display("FAIL ws15[%0d]: got lat=%0d rd=%h err=%b expected lat=16 rd=%h err=0", j, lat, rd, e, mrd);
      end
    end
    // req_valid held: accepts every 18 cycles, response 17 cycles after each accept cycle
    @(negedge clk);
    req_we = 1'b0; req_size = 3'b010; address = 32'h40; req_valid[3] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      vectors++;
      if (req_ready[3] !== ((n % 18) == 0) || resp_valid[3] !== ((n % 18) == 17)) begin
        miscompares++;
        $display("FAIL held_valid[%0d]: got ready=%b resp=%b expected ready=%b resp=%b",
                 n, req_ready[3], resp_valid[3], ((n % 18) == 0), ((n % 18) == 17));
      end
      @(negedge clk);
    end
    req_valid[3] = 1'b0;
    guard = 0;
    while (!req_ready[3] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (req_ready[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL held_valid_drain: got ready=%b expected 1", req_ready[3]);
    end
  endtask

  function automatic logic [2:0] pick_size(input int r);
    case (r)
      0, 5, 10:  return 3'b000;
      1, 6, 11:  return 3'b001;
      2, 7, 12:  return 3'b010;
      3, 8, 13:  return 3'b100;
      4, 9, 14:  return 3'b101;
      15:        return 3'b011;
      16:        return 3'b110;
      default:   return 3'b111;
    endcase
  endfunction

  task automatic test_back_to_back;
    logic [31:0] rd, mrd, addr, wd; logic [2:0] size; bit we, e, me, oc; int lat, mlat;
    for (int i = 0; i < 200; i++) begin
      we   = 1'($urandom_range(0, 1));
      size = pick_size($urandom_range(0, 17));
      addr = $urandom & 32'hFFFF_F03F;
      if ($urandom_range(0, 3) != 0) begin
        if (size[1:0] == 2'b01) addr[0] = 1'b0;
        if (size[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      wd = $urandom;
      model_access(0, we, size, addr, wd, mrd, me, mlat);
      do_access(0, we, size, addr, wd, rd, e, lat, oc);
      vectors++;
      if (rd !== mrd || e !== me || lat !== mlat || !oc) begin
        miscompares++;
        $display("FAIL random[%0d] we=%b size=%b addr=%h: got rd=%h err=%b lat=%0d pulse1=%b expected rd=%h err=%b lat=%0d pulse1=1",
                 i, we, size, addr, rd, e, lat, oc, mrd, me, mlat);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < DEPTH*4; b++) mdl[k][b] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_word_rw();
    test_subword();
    test_errors();
    test_wrap();
    test_reset_abort();
    test_latency();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
